// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback states
// and drives the datapath strobes and mux selects for the current state.
module multicycle_control_unit #(
   parameter int ALU_CTRL_W  = 4,
   parameter int MEM_WAIT    = 1,
   parameter int ENABLE_JUMP = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  pc_write_cond,
   output logic                  iord,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  mem_to_reg,
   output logic                  reg_dst,
   output logic                  reg_write,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            pc_source,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic [3:0]            state,
   output logic                  illegal
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_RD    = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WR    = 4'd5,
      EXEC      = 4'd6,
      ALU_WB    = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11,
      TRAP      = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_t     state_q, state_d;
   logic       ready;
   logic       funct_ok;
   logic [3:0] funct_alu;
   logic [3:0] alu_op;

   // With MEM_WAIT=0 the memory is assumed single-cycle and mem_ready is ignored.
   assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default: begin
            funct_ok  = 1'b0;
            funct_alu = 4'b0000;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   // NOTE: every output and state_d gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = 4'b0000;
      illegal       = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = ALU_ADD;
            ir_write  = ready;
            pc_write  = ready;
            state_d   = ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_R:         state_d = funct_ok ? EXEC : TRAP;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = (ENABLE_JUMP != 0) ? JUMP : TRAP;
               OP_ADDI:      state_d = ADDI_EXEC;
               default:      state_d = TRAP;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
            state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = ready ? MEM_WB : MEM_RD;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            state_d   = ready ? FETCH : MEM_WR;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = funct_alu;
            state_d   = ALU_WB;
         end
         ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
            state_d   = ADDI_WB;
         end
         ADDI_WB:  reg_write = 1'b1;
         TRAP:     illegal   = 1'b1;
         // Unused codes 13-15 recover to FETCH with every control low.
         default:  state_d   = FETCH;
      endcase
   end

   assign alu_control = ALU_CTRL_W'(alu_op);
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default build plus an 8-bit
// alu_control build with jumps disabled, both driven from the same inputs.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [3:0] alu;
      logic       illegal;
   } ctrl_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;

   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
   logic [1:0] alu_src_b, pc_source;
   logic [3:0] alu_control, state;

   logic       b_pc_write, b_pc_write_cond, b_iord, b_mem_read, b_mem_write, b_ir_write;
   logic       b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a, b_illegal;
   logic [1:0] b_alu_src_b, b_pc_source;
   logic [7:0] b_alu_control;
   logic [3:0] b_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .alu_control(alu_control), .state(state), .illegal(illegal)
   );

   multicycle_control_unit #(.ALU_CTRL_W(8), .MEM_WAIT(1), .ENABLE_JUMP(0)) dut_b (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .iord(b_iord),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
      .mem_to_reg(b_mem_to_reg), .reg_dst(b_reg_dst), .reg_write(b_reg_write),
      .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .pc_source(b_pc_source),
      .alu_control(b_alu_control), .state(b_state), .illegal(b_illegal)
   );

   ctrl_t obs, obs_b;
   assign obs   = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                   alu_control, illegal};
   assign obs_b = {b_pc_write, b_pc_write_cond, b_iord, b_mem_read, b_mem_write, b_ir_write,
                   b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a, b_alu_src_b, b_pc_source,
                   b_alu_control[3:0], b_illegal};

   // Expected control word for a state, written out from the state table.
   function automatic ctrl_t exp_ctrl(int st, logic rdy, logic [3:0] fa);
      ctrl_t c;
      c = '0;
      case (st)
         0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu = 4'b0010;
                   c.ir_write = rdy; c.pc_write = rdy; end
         1:  begin c.alu_src_b = 2'b11; c.alu = 4'b0010; end
         2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu = 4'b0010; end
         3:  begin c.mem_read = 1; c.iord = 1; end
         4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
         5:  begin c.mem_write = 1; c.iord = 1; end
         6:  begin c.alu_src_a = 1; c.alu = fa; end
         7:  begin c.reg_write = 1; c.reg_dst = 1; end
         8:  begin c.alu_src_a = 1; c.alu = 4'b0110; c.pc_write_cond = 1; c.pc_source = 2'b01; end
         9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
         10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu = 4'b0010; end
         11: c.reg_write = 1;
         12: c.illegal = 1;
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; opcode = 6'b100011; funct = 6'b100000; mem_ready = 1'b1;
      step(); step();
      total++;
      if (state !== 4'd0 || obs !== exp_ctrl(0, 1'b1, 4'b0)) begin
         bad++; $display("FAIL reset_ready state=%0d ctrl=%h want state=0 ctrl=%h", state, obs, exp_ctrl(0, 1'b1, 4'b0));
      end
      mem_ready = 1'b0; #1;
      total++;
      if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
         bad++; $display("FAIL reset_not_ready ir_write=%b pc_write=%b mem_read=%b want 0 0 1", ir_write, pc_write, mem_read);
      end
      total++;
      if (b_alu_control !== 8'h02 || b_state !== 4'd0) begin
         bad++; $display("FAIL reset_wide alu_control=%h state=%0d want 02 0", b_alu_control, b_state);
      end
      rst = 1'b0; mem_ready = 1'b1;
   endtask

   task automatic test_lw_sw();
      int seq[$];
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 6'b100011 : 6'b101011;
         seq = (k == 0) ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
         for (int i = 0; i < seq.size(); i++) begin
            #1; total++;
            if (state !== 4'(seq[i]) || obs !== exp_ctrl(seq[i], 1'b1, 4'b0)) begin
               bad++; $display("FAIL lw_sw[%0d.%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                               k, i, state, obs, seq[i], exp_ctrl(seq[i], 1'b1, 4'b0));
            end
            step();
         end
         total++;
         if (state !== 4'd0) begin
            bad++; $display("FAIL lw_sw_end[%0d] state=%0d want 0", k, state);
         end
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fn [5] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
      logic [3:0] fa [5] = '{4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0111};
      int seq[4] = '{0, 1, 6, 7};
      opcode = 6'b000000;
      for (int k = 0; k < 5; k++) begin
         funct = fn[k];
         for (int i = 0; i < 4; i++) begin
            #1; total++;
            if (state !== 4'(seq[i]) || obs !== exp_ctrl(seq[i], 1'b1, fa[k])) begin
               bad++; $display("FAIL rtype[%0d.%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                               k, i, state, obs, seq[i], exp_ctrl(seq[i], 1'b1, fa[k]));
            end
            step();
         end
      end
      total++;
      if (state !== 4'd0) begin
         bad++; $display("FAIL rtype_end state=%0d want 0", state);
      end
   endtask

   task automatic test_illegal();
      int seq[4] = '{0, 1, 12, 0};
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 6'b111111 : 6'b000000;
         funct  = 6'b000000;
         for (int i = 0; i < 4; i++) begin
            #1; total++;
            if (state !== 4'(seq[i]) || obs !== exp_ctrl(seq[i], 1'b1, 4'b0)) begin
               bad++; $display("FAIL illegal[%0d.%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                               k, i, state, obs, seq[i], exp_ctrl(seq[i], 1'b1, 4'b0));
            end
            if (i < 3) step();
         end
      end
   endtask

   task automatic test_addi();
      int seq[4] = '{0, 1, 10, 11};
      opcode = 6'b001000;
      for (int i = 0; i < 4; i++) begin
         #1; total++;
         if (state !== 4'(seq[i]) || obs !== exp_ctrl(seq[i], 1'b1, 4'b0)) begin
            bad++; $display("FAIL addi[%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                            i, state, obs, seq[i], exp_ctrl(seq[i], 1'b1, 4'b0));
         end
         step();
      end
   endtask

   task automatic test_mem_wait();
      int  seq_lw[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
      logic rdy_lw[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      int  seq_sw[6] = '{0, 0, 1, 2, 5, 5};
      logic rdy_sw[6] = '{0, 1, 1, 1, 0, 1};
      opcode = 6'b100011;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rdy_lw[i]; #1; total++;
         if (state !== 4'(seq_lw[i]) || obs !== exp_ctrl(seq_lw[i], rdy_lw[i], 4'b0)) begin
            bad++; $display("FAIL lw_wait[%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                            i, state, obs, seq_lw[i], exp_ctrl(seq_lw[i], rdy_lw[i], 4'b0));
         end
         step();
      end
      opcode = 6'b101011;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy_sw[i]; #1; total++;
         if (state !== 4'(seq_sw[i]) || obs !== exp_ctrl(seq_sw[i], rdy_sw[i], 4'b0)) begin
            bad++; $display("FAIL sw_wait[%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                            i, state, obs, seq_sw[i], exp_ctrl(seq_sw[i], rdy_sw[i], 4'b0));
         end
         step();
      end
      total++;
      if (state !== 4'd0) begin
         bad++; $display("FAIL wait_end state=%0d want 0", state);
      end
   endtask

   task automatic test_branch_jump();
      int seq[3];
      int seq_b[3] = '{0, 1, 12};
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 6'b000100 : 6'b000010;
         seq = (k == 0) ? '{0, 1, 8} : '{0, 1, 9};
         for (int i = 0; i < 3; i++) begin
            #1; total++;
            if (state !== 4'(seq[i]) || obs !== exp_ctrl(seq[i], 1'b1, 4'b0)) begin
               bad++; $display("FAIL branch_jump[%0d.%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                               k, i, state, obs, seq[i], exp_ctrl(seq[i], 1'b1, 4'b0));
            end
            if (k == 1) begin
               total++;
               if (b_state !== 4'(seq_b[i]) || obs_b !== exp_ctrl(seq_b[i], 1'b1, 4'b0)) begin
                  bad++; $display("FAIL jump_disabled[%0d] state=%0d ctrl=%h want state=%0d ctrl=%h",
                                  i, b_state, obs_b, seq_b[i], exp_ctrl(seq_b[i], 1'b1, 4'b0));
               end
            end
            step();
         end
      end
   endtask

   task automatic test_reset_midway();
      opcode = 6'b101011; mem_ready = 1'b1;
      step(); step(); step();
      mem_ready = 1'b0; #1;
      total++;
      if (state !== 4'd5 || mem_write !== 1'b1) begin
         bad++; $display("FAIL rst_setup state=%0d mem_write=%b want 5 1", state, mem_write);
      end
      rst = 1'b1;
      step();
      total++;
      if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
         bad++; $display("FAIL rst_mem_wr state=%0d mem_write=%b reg_write=%b pc_write=%b want 0 0 0 0",
                         state, mem_write, reg_write, pc_write);
      end
      total++;
      if (b_state !== 4'd0 || b_mem_write !== 1'b0 || b_alu_control !== 8'b00000010) begin
         bad++; $display("FAIL rst_wide state=%0d mem_write=%b alu_control=%b want 0 0 00000010",
                         b_state, b_mem_write, b_alu_control);
      end
      rst = 1'b0; opcode = 6'b100011; mem_ready = 1'b1;
      step(); step(); step();
      mem_ready = 1'b0; rst = 1'b1;
      step();
      total++;
      if (state !== 4'd0 || reg_write !== 1'b0 || iord !== 1'b0) begin
         bad++; $display("FAIL rst_mem_rd state=%0d reg_write=%b iord=%b want 0 0 0", state, reg_write, iord);
      end
      rst = 1'b0; mem_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lw_sw();
      test_rtype();
      test_illegal();
      test_addi();
      test_mem_wait();
      test_branch_jump();
      test_reset_midway();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter ALU_CTRL_W, default 4, the width of alu_control (legal values >= 4).
REQ-002 The block SHALL have parameter MEM_WAIT, default 1; 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-003 The block SHALL have parameter ENABLE_JUMP, default 1; 0 = opcode 000010 is illegal.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 opcode  in  6  instruction opcode, valid from DECODE onward, held stable by the IR.
REQ-007 funct  in  6  instruction funct field, same timing as opcode.
REQ-008 mem_ready  in  1  memory access completes this cycle.
REQ-009 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  standard multicycle datapath controls.
REQ-010 alu_src_b, pc_source  out  2 each  datapath mux selects.
REQ-011 alu_control  out  ALU_CTRL_W  ALU operation; the encoding occupies bits [3:0] and upper bits SHALL be 0.
REQ-012 state  out  4  current state code, for debug.
REQ-013 illegal  out  1  one-cycle pulse on an unsupported opcode or funct.

Function
REQ-014 States and codes SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=12; codes 13-15 SHALL go to FETCH on the next cycle with all controls deasserted.
REQ-015 Decoded opcodes SHALL be: R-type=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
REQ-016 Decoded R-type funct and alu_control values SHALL be: add 100000->0010, sub 100010->0110, and 100100->0000, or 100101->0001, slt 101010->0111.
REQ-017 FETCH SHALL drive mem_read=1, alu_src_b=01, alu_control=ADD, and ir_write=pc_write=mem_ready; it SHALL hold while mem_ready=0 and advance to DECODE when mem_ready=1.
REQ-018 DECODE SHALL drive alu_src_b=11 and alu_control=ADD, then branch by opcode: lw/sw->MEM_ADDR, R->EXEC, beq->BRANCH, j->JUMP, addi->ADDI_EXEC, anything else->TRAP.
REQ-019 In DECODE, an R-type instruction with an undecoded funct SHALL go to TRAP, not EXEC.
REQ-020 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_control=ADD, then go to MEM_RD for lw or MEM_WR for sw.
REQ-021 MEM_RD SHALL drive mem_read=1, iord=1, and hold until mem_ready, then go to MEM_WB.
REQ-022 MEM_WR SHALL drive mem_write=1, iord=1, and hold until mem_ready, then go to FETCH.
REQ-023 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-024 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_control from funct, then go to ALU_WB.
REQ-025 ALU_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-026 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_control=SUB, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-027 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-028 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_control=ADD, then go to ADDI_WB.
REQ-029 ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-030 TRAP SHALL drive illegal=1 with all other controls 0, then go to FETCH.
REQ-031 Every control not listed for a state SHALL be 0, and alu_control SHALL be 0 in such states.
REQ-032 With mem_ready=1 throughout, cycles per instruction SHALL be: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 3.
REQ-033 Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle, with outputs unchanged apart from ir_write and pc_write in FETCH.

Reset
REQ-034 While rst=1 at a rising edge, the next state SHALL be FETCH, regardless of current state or mem_ready.
REQ-035 After reset, outputs SHALL be the FETCH values: mem_read=1, alu_src_b=01, alu_control=0010, all other outputs 0 except ir_write/pc_write=mem_ready.
REQ-036 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no reg_write, mem_write or pc_write pulse after the reset edge.

Verification
REQ-037 Scenario: mem_ready=1, lw then sw -> state 0,1,2,3,4 with reg_write=1 only in state 4; then 0,1,2,5 with mem_write=1 only in state 5.
REQ-038 Scenario: R-type with funct 100010 -> EXEC alu_control=0110, ALU_WB reg_dst=1, reg_write=1; repeat for funct 100000, 100100, 100101, 101010 -> 0010, 0000, 0001, 0111.
REQ-039 Scenario: opcode 111111, then R-type with funct 000000 -> each gives state 0,1,12 with illegal=1 for exactly one cycle and no write strobes.
REQ-040 Scenario: lw with mem_ready=0 for 3 cycles in MEM_RD -> 8 cycles total, mem_read/iord held, MEM_WB entered only after mem_ready=1.
REQ-041 Scenario: beq and j -> BRANCH pc_write_cond=1, pc_source=01; JUMP pc_write=1, pc_source=10; with ENABLE_JUMP=0, j -> TRAP.
REQ-042 Scenario: rst=1 in MEM_WR with mem_ready=0, and ALU_CTRL_W=8 build -> next state 0, mem_write=0, alu_control=00000010.
